// File: rtl/ccff_bitstream_loader.sv
// rtl/ccff_bitstream_loader.sv - serializes bitstream words MSB-first into the fabric ccff chain.
// Optional CCFF_READBACK_EN captures ccff_tail into left-aligned rb_data words with an rb_valid pulse.
module ccff_bitstream_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              chain_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done
`ifdef CCFF_READBACK_EN
    ,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
`endif
);

    localparam int BW = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] WORD_W_CNT    = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CHAIN_LEN_CNT = CNT_W'(CHAIN_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_WORD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  remaining;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     bits_this;
    logic              accept;
    logic              last_bit;
    logic              load_start;

    assign last_bit   = (bit_cnt == bits_this - BW'(1));
    assign load_start = (state == S_IDLE) && start && !abort;

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs decode from state so a reset drops chain_en without waiting for a clock.
    always_comb begin
        state_next = state;
        cfg_ready  = 1'b0;
        chain_en   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_start) begin
                    state_next = S_WAIT_WORD;
                end
            end
            S_WAIT_WORD: begin
                busy      = 1'b1;
                cfg_ready = !abort;
                if (abort) begin
                    state_next = S_IDLE;
                end else if (cfg_valid) begin
                    accept     = 1'b1;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy     = 1'b1;
                chain_en = 1'b1;
                if (abort) begin
                    state_next = S_IDLE;
                end else if (last_bit) begin
                    state_next = (remaining == CNT_W'(1)) ? S_DONE : S_WAIT_WORD;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            shreg     <= '0;
            remaining <= '0;
            bit_cnt   <= '0;
            bits_this <= '0;
            ccff_head <= 1'b0;
        end else begin
            if (load_start) begin
                remaining <= CHAIN_LEN_CNT;
            end
            if (accept) begin
                // The first bit goes straight to ccff_head so the shift starts with no extra bubble.
                ccff_head <= cfg_data[WORD_W-1];
                shreg     <= {cfg_data[WORD_W-2:0], 1'b0};
                bit_cnt   <= '0;
                bits_this <= (remaining >= WORD_W_CNT) ? BW'(WORD_W) : BW'(remaining);
            end else if (state == S_SHIFT) begin
                shreg     <= {shreg[WORD_W-2:0], 1'b0};
                remaining <= remaining - CNT_W'(1);
                bit_cnt   <= bit_cnt + BW'(1);
                if (!last_bit) begin
                    ccff_head <= shreg[WORD_W-1];
                end
            end
        end
    end

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] rb_shreg;
    logic [WORD_W-1:0] rb_next;

    // Tail bits land MSB-first at their final position, leaving unused LSBs of a partial word at 0.
    always_comb begin
        rb_next = rb_shreg;
        rb_next[WORD_W - 1 - int'(bit_cnt)] = ccff_tail;
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            rb_shreg <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (accept) begin
                rb_shreg <= '0;
            end else if (state == S_SHIFT && !abort) begin
                rb_shreg <= rb_next;
                if (last_bit) begin
                    rb_data  <= rb_next;
                    rb_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb/tb_ccff_bitstream_loader.sv - directed bench for ccff_bitstream_loader with 16- and 20-bit chain models.
module tb_ccff_bitstream_loader;

    logic       prog_clk   = 1'b0;
    logic       prog_reset = 1'b1;
    logic       start      = 1'b0;
    logic       abort      = 1'b0;
    logic       cfg_valid  = 1'b0;
    logic [7:0] cfg_data   = 8'h00;
    logic       sel        = 1'b0;

    logic rdy16, head16, en16, busy16, done16;
    logic rdy20, head20, en20, busy20, done20;
    logic [15:0] chain16 = 16'h5AC3;
    logic [19:0] chain20 = 20'h12345;

    int n_checks = 0;
    int n_errors = 0;
    int en_cnt = 0, busy_cnt = 0, rdy_cnt = 0, hs_cnt = 0, done_cnt = 0;
    logic [63:0] head_bits = '0;

    logic en, busy, rdy, done, head;
    assign en   = sel ? en20   : en16;
    assign busy = sel ? busy20 : busy16;
    assign rdy  = sel ? rdy20  : rdy16;
    assign done = sel ? done20 : done16;
    assign head = sel ? head20 : head16;

`ifdef CCFF_READBACK_EN
    logic [7:0] rbd16, rbd20;
    logic       rbv16, rbv20;
    logic [7:0] rb16_q[$];
    logic [7:0] rb20_q[$];
`endif

    ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(16), .CNT_W(16)) u_dut16 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start & ~sel), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy16), .ccff_head(head16),
        .chain_en(en16), .ccff_tail(chain16[15]), .busy(busy16), .done(done16)
`ifdef CCFF_READBACK_EN
        , .rb_data(rbd16), .rb_valid(rbv16)
`endif
    );

    ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(20), .CNT_W(16)) u_dut20 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start & sel), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy20), .ccff_head(head20),
        .chain_en(en20), .ccff_tail(chain20[19]), .busy(busy20), .done(done20)
`ifdef CCFF_READBACK_EN
        , .rb_data(rbd20), .rb_valid(rbv20)
`endif
    );

    always #5 prog_clk = ~prog_clk;

    // Behavioural configuration chains: capture ccff_head on every chain_en edge.
    always @(posedge prog_clk) begin
        if (en16) chain16 <= {chain16[14:0], head16};
        if (en20) chain20 <= {chain20[18:0], head20};
    end

    always @(negedge prog_clk) begin
        if (en) begin
            en_cnt++;
            head_bits = {head_bits[62:0], head};
        end
        if (busy) busy_cnt++;
        if (rdy) rdy_cnt++;
        if (rdy && cfg_valid) hs_cnt++;
        if (done) done_cnt++;
`ifdef CCFF_READBACK_EN
        if (rbv16) rb16_q.push_back(rbd16);
        if (rbv20) rb20_q.push_back(rbd20);
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!rdy && k < 100) begin
            step();
            k++;
        end
        if (k >= 100) check({tag, "_ready_timeout"}, 32'(rdy), 32'd1);
    endtask

    task automatic run_load(input string tag, input logic s, input int nw,
                            input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input int gap, input int exp_bits, input int exp_busy,
                            input logic [31:0] exp_bits_val);
        int b_en, b_busy, b_rdy, b_hs, b_done, k;
        logic [7:0] words [3];
        logic [63:0] mask;
        logic gap_bad;
        words[0] = w0; words[1] = w1; words[2] = w2;
        sel = s;
        gap_bad = 1'b0;
        b_en = en_cnt; b_busy = busy_cnt; b_rdy = rdy_cnt; b_hs = hs_cnt; b_done = done_cnt;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < nw; i++) begin
            if (i == 1 && gap > 0) begin
                cfg_valid = 1'b0;
                wait_ready(tag);
                for (int g = 0; g < gap; g++) begin
                    if (en || !rdy) gap_bad = 1'b1;
                    step();
                end
            end
            cfg_data  = words[i];
            cfg_valid = 1'b1;
            wait_ready(tag);
            step();
        end
        cfg_valid = 1'b0;
        k = 0;
        while (!done && k < 100) begin
            step();
            k++;
        end
        if (k >= 100) check({tag, "_done_timeout"}, 32'(done), 32'd1);
        step();
        step();
        mask = (64'd1 << exp_bits) - 64'd1;
        check({tag, "_en_cycles"}, 32'(en_cnt - b_en), 32'(exp_bits));
        check({tag, "_busy_cycles"}, 32'(busy_cnt - b_busy), 32'(exp_busy));
        check({tag, "_handshakes"}, 32'(hs_cnt - b_hs), 32'(nw));
        check({tag, "_done_pulses"}, 32'(done_cnt - b_done), 32'd1);
        check({tag, "_head_seq"}, 32'(head_bits & mask), exp_bits_val);
        check({tag, "_chain"}, s ? 32'(chain20) : 32'(chain16), exp_bits_val);
        check({tag, "_idle_after"}, {30'd0, busy, en}, 32'd0);
        if (gap > 0) check({tag, "_gap_hold"}, 32'(gap_bad), 32'd0);
        if (s) check({tag, "_ready_cycles"}, 32'(rdy_cnt - b_rdy), 32'(nw));
    endtask

    initial begin
        int b_en, b_done;

        #2;
        check("reset16_outputs", {27'd0, rdy16, head16, en16, busy16, done16}, 32'd0);
        check("reset20_outputs", {27'd0, rdy20, head20, en20, busy20, done20}, 32'd0);
        step();
        prog_reset = 1'b0;
        step();

        // start and abort together in IDLE must not begin a load
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", {30'd0, busy16, rdy16}, 32'd0);

        run_load("w16", 1'b0, 2, 8'hA5, 8'h3C, 8'h00, 0, 16, 18, 32'h0000A53C);
`ifdef CCFF_READBACK_EN
        check("rb16_count", 32'(rb16_q.size()), 32'd2);
        check("rb16_word0", (rb16_q.size() > 0) ? 32'(rb16_q[0]) : 32'hDEAD, 32'h5A);
        check("rb16_word1", (rb16_q.size() > 1) ? 32'(rb16_q[1]) : 32'hDEAD, 32'hC3);
`endif

        run_load("w20", 1'b1, 3, 8'hFF, 8'h00, 8'hB7, 0, 20, 23, 32'h000FF00B);
`ifdef CCFF_READBACK_EN
        check("rb20_count", 32'(rb20_q.size()), 32'd3);
        check("rb20_word0", (rb20_q.size() > 0) ? 32'(rb20_q[0]) : 32'hDEAD, 32'h12);
        check("rb20_word1", (rb20_q.size() > 1) ? 32'(rb20_q[1]) : 32'hDEAD, 32'h34);
        check("rb20_partial", (rb20_q.size() > 2) ? 32'(rb20_q[2]) : 32'hDEAD, 32'h50);
`endif

        run_load("gap16", 1'b0, 2, 8'h96, 8'h0F, 8'h00, 5, 16, 23, 32'h0000960F);

        // abort during the third shifted bit of the first word
        sel = 1'b0;
        b_en = en_cnt;
        b_done = done_cnt;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_data = 8'hE7;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_next_idle", {29'd0, rdy16, busy16, en16}, 32'd0);
        repeat (5) step();
        check("abort_en_cycles", 32'(en_cnt - b_en), 32'd3);
        check("abort_no_done", 32'(done_cnt - b_done), 32'd0);
        check("abort_chain_bits", 32'(chain16[2:0]), 32'd7);

        run_load("after_abort", 1'b0, 2, 8'h81, 8'h7E, 8'h00, 0, 16, 18, 32'h0000817E);

        // asynchronous reset in the middle of a shift
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_data = 8'h55;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        #3;
        prog_reset = 1'b1;
        #1;
        check("midload_reset", {27'd0, rdy16, head16, en16, busy16, done16}, 32'd0);
        step();
        prog_reset = 1'b0;
        step();

        run_load("after_reset", 1'b0, 2, 8'hC9, 8'h36, 8'h00, 0, 16, 18, 32'h0000C936);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
